// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RELEASE = 2'b01,
    RUN     = 2'b10
  } seq_state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter for an active-low button.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall_pulse
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        // Only a released->pressed flip is a press event.
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level      = level_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/reset_sequencer.sv
// Conditions board, button and soft resets and releases per-domain stage resets
// in index order after a minimum hold.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned MIN_PULSE       = 8,
  parameter int unsigned STAGE_DELAY     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  btn_n,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic [1:0]            reset_cause
);

  localparam int unsigned HW = cnt_width(MIN_PULSE);
  localparam int unsigned DW = cnt_width(STAGE_DELAY);
  localparam int unsigned IW = cnt_width(NUM_STAGES);

  logic rst_meta_q, rst_ok_q;
  logic btn_level, btn_press;

  seq_state_e            state_q, state_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [DW-1:0]         dly_cnt_q, dly_cnt_d;
  logic [IW-1:0]         stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                  all_rel_q, all_rel_d;
  logic [1:0]            cause_q, cause_d;

  // Assertion is immediate; deassertion is seen by the FSM two edges later.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rst_meta_q <= 1'b0;
      rst_ok_q   <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_ok_q   <= rst_meta_q;
    end
  end

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (sys_clk),
    .rst_n      (sys_reset_n),
    .din        (btn_n),
    .level      (btn_level),
    .fall_pulse (btn_press)
  );

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    dly_cnt_d     = dly_cnt_q;
    stage_idx_d   = stage_idx_q;
    stage_reset_d = stage_reset_q;
    all_rel_d     = all_rel_q;
    cause_d       = cause_q;

    if (rst_ok_q) begin
      unique case (state_q)
        HOLD: begin
          if (!btn_level) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HW'(MIN_PULSE - 1)) begin
            // Stage 0 is released on the same edge the hold ends.
            stage_reset_d = stage_reset_q << 1;
            hold_cnt_d    = '0;
            dly_cnt_d     = '0;
            stage_idx_d   = IW'(1);
            if (NUM_STAGES == 1) begin
              all_rel_d = 1'b1;
              state_d   = RUN;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (dly_cnt_q == DW'(STAGE_DELAY - 1)) begin
            dly_cnt_d     = '0;
            stage_reset_d = stage_reset_q << 1;
            stage_idx_d   = stage_idx_q + 1'b1;
            if (stage_idx_q == IW'(NUM_STAGES - 1)) begin
              all_rel_d = 1'b1;
              state_d   = RUN;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        RUN: begin
        end
        default: begin
          state_d = HOLD;
        end
      endcase

      // Re-entry overrides the release progress; button outranks soft request.
      if ((state_q != HOLD) && (btn_press || sw_reset_req)) begin
        state_d       = HOLD;
        stage_reset_d = '1;
        all_rel_d     = 1'b0;
        hold_cnt_d    = '0;
        dly_cnt_d     = '0;
        stage_idx_d   = '0;
        cause_d       = btn_press ? CAUSE_BTN : CAUSE_SOFT;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      dly_cnt_q     <= '0;
      stage_idx_q   <= '0;
      stage_reset_q <= '1;
      all_rel_q     <= 1'b0;
      cause_q       <= CAUSE_EXT;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      dly_cnt_q     <= dly_cnt_d;
      stage_idx_q   <= stage_idx_d;
      stage_reset_q <= stage_reset_d;
      all_rel_q     <= all_rel_d;
      cause_q       <= cause_d;
    end
  end

  assign stage_reset  = stage_reset_q;
  assign all_released = all_rel_q;
  assign reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their edge
// number; a monitor pops and compares on every observed output change.
module tb_reset_sequencer;

  logic       sys_clk      = 1'b0;
  logic       sys_reset_n  = 1'b1;
  logic       btn_n        = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic [2:0] stage_reset;
  logic       all_released;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         edge_n;
    logic [2:0] sr;
    logic       ar;
    logic [1:0] cause;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_x;
  logic [5:0] mon_prev;
  logic [5:0] mon_cur;

  reset_sequencer dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .btn_n        (btn_n),
    .sw_reset_req (sw_reset_req),
    .stage_reset  (stage_reset),
    .all_released (all_released),
    .reset_cause  (reset_cause)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge numbering: edge 1 is the first rise with sys_reset_n high.
  always @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) cyc <= 0;
    else              cyc <= cyc + 1;
  end

  always @(negedge sys_clk) begin
    if (mon_en) begin
      mon_cur = {stage_reset, all_released, reset_cause};
      if (mon_cur !== mon_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: edge %0d sr=%b ar=%b cause=%b, expected no change",
                   cyc, stage_reset, all_released, reset_cause);
        end else begin
          mon_x = sb.pop_front();
          if (mon_x.edge_n != cyc || mon_cur !== {mon_x.sr, mon_x.ar, mon_x.cause}) begin
            errors++;
            $display("FAIL out_event: edge %0d sr=%b ar=%b cause=%b, expected edge %0d sr=%b ar=%b cause=%b",
                     cyc, stage_reset, all_released, reset_cause,
                     mon_x.edge_n, mon_x.sr, mon_x.ar, mon_x.cause);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic expect_ev(input int e, input logic [2:0] sr, input logic ar, input logic [1:0] c);
    exp_t x;
    x.edge_n = e;
    x.sr     = sr;
    x.ar     = ar;
    x.cause  = c;
    sb.push_back(x);
  endtask

  task automatic expect_seq(input int hold_edge, input logic [1:0] c);
    expect_ev(hold_edge + 8,  3'b110, 1'b0, c);
    expect_ev(hold_edge + 12, 3'b100, 1'b0, c);
    expect_ev(hold_edge + 16, 3'b000, 1'b1, c);
  endtask

  task automatic at_neg(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge sys_clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_edge: reached edge %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic check_now(input string name, input logic [2:0] sr, input logic ar, input logic [1:0] c);
    checks++;
    if ({stage_reset, all_released, reset_cause} !== {sr, ar, c}) begin
      errors++;
      $display("FAIL %s: got sr=%b ar=%b cause=%b, expected sr=%b ar=%b cause=%b",
               name, stage_reset, all_released, reset_cause, sr, ar, c);
    end
  endtask

  initial begin
    #1 sys_reset_n = 1'b0;
    #1 check_now("reset_state", 3'b111, 1'b0, 2'b00);
    mon_prev = {3'b111, 1'b0, 2'b00};
    mon_en   = 1'b1;

    // Power-up
    repeat (5) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    expect_seq(2, 2'b00);

    // Soft reset in RUN, sampled at edge 26
    at_neg(25); sw_reset_req = 1'b1;
    expect_ev(26, 3'b111, 1'b0, 2'b10);
    expect_seq(26, 2'b10);
    at_neg(26); sw_reset_req = 1'b0;

    // Soft reset, then another request inside HOLD that must be ignored
    at_neg(50); sw_reset_req = 1'b1;
    expect_ev(51, 3'b111, 1'b0, 2'b10);
    expect_seq(51, 2'b10);
    at_neg(51); sw_reset_req = 1'b0;
    at_neg(54); sw_reset_req = 1'b1;
    at_neg(55); sw_reset_req = 1'b0;

    // Button held 40 cycles: reset at relative edge 19, hold extended to debounced release
    at_neg(75); btn_n = 1'b0;
    expect_ev(94, 3'b111, 1'b0, 2'b01);
    expect_seq(133, 2'b01);
    at_neg(115); btn_n = 1'b1;

    // Glitchy button: must not trigger
    at_neg(160); btn_n = 1'b0;
    repeat (10) @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      btn_n = 1'b0;
      repeat (3) @(negedge sys_clk);
    end
    btn_n = 1'b1;
    at_neg(203);
    check_now("glitch_no_reset", 3'b000, 1'b1, 2'b01);

    // Soft reset to set cause=10 before the simultaneous case
    at_neg(205); sw_reset_req = 1'b1;
    expect_ev(206, 3'b111, 1'b0, 2'b10);
    expect_seq(206, 2'b10);
    at_neg(206); sw_reset_req = 1'b0;

    // Press event and soft request on the same edge (249): button wins
    at_neg(230); btn_n = 1'b0;
    expect_ev(249, 3'b111, 1'b0, 2'b01);
    expect_seq(278, 2'b01);
    at_neg(248); sw_reset_req = 1'b1;
    at_neg(249); sw_reset_req = 1'b0;
    at_neg(260); btn_n = 1'b1;

    // Async reset with stage 0 released and stages 1..2 still held
    at_neg(300); sw_reset_req = 1'b1;
    expect_ev(301, 3'b111, 1'b0, 2'b10);
    expect_ev(309, 3'b110, 1'b0, 2'b10);
    at_neg(301); sw_reset_req = 1'b0;
    at_neg(311);
    #2 sys_reset_n = 1'b0;
    expect_ev(0, 3'b111, 1'b0, 2'b00);
    #1 check_now("async_mid_soft", 3'b111, 1'b0, 2'b00);
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    expect_ev(10, 3'b110, 1'b0, 2'b00);

    // Async reset between edges 12 and 13 of the restarted sequence
    at_neg(12);
    #2 sys_reset_n = 1'b0;
    expect_ev(0, 3'b111, 1'b0, 2'b00);
    #1 check_now("async_edge12", 3'b111, 1'b0, 2'b00);
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    expect_seq(2, 2'b00);

    for (int g = 0; g < 100 && sb.size() > 0; g++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected changes not seen, required 0", sb.size());
    end
    repeat (5) @(negedge sys_clk);
    check_now("final_run", 3'b000, 1'b1, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
